// File: rtl/dff_cfg_pkg.sv
// Shared types for the configurable flip-flop and its passive configuration identifier.
package dff_cfg_pkg;

    localparam int unsigned CFG_W = 3;

    // Field order fixes the code: bit2 async reset, bit1 negedge clock, bit0 active-low reset.
    typedef struct packed {
        logic async_rst;
        logic neg_edge;
        logic rst_low;
    } cfg_t;

    typedef enum logic [CFG_W-1:0] {
        CFG_POS_SYNC_HIGH  = 3'd0,
        CFG_POS_SYNC_LOW   = 3'd1,
        CFG_NEG_SYNC_HIGH  = 3'd2,
        CFG_NEG_SYNC_LOW   = 3'd3,
        CFG_POS_ASYNC_HIGH = 3'd4,
        CFG_POS_ASYNC_LOW  = 3'd5,
        CFG_NEG_ASYNC_HIGH = 3'd6,
        CFG_NEG_ASYNC_LOW  = 3'd7
    } cfg_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OBSERVE,
        ST_DECIDE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dff_cfg_evidence.sv
// Probe sample pipeline, event decode and saturating evidence counters.
module dff_cfg_evidence
    import dff_cfg_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             observe,
    input  logic             probe_clk,
    input  logic             probe_rst,
    input  logic             probe_d,
    input  logic             probe_q,
    output logic [CNT_W-1:0] pos_hits,
    output logic [CNT_W-1:0] neg_hits,
    output logic [CNT_W-1:0] hold_hi,
    output logic [CNT_W-1:0] hold_lo,
    output logic [CNT_W-1:0] async_hits
);

    logic s_clk, s_rst, s_d, s_q;
    logic p_clk, p_rst, p_d, p_q;
    logic s_obs, p_obs;
    logic pe, ne, qchg, armed, count_en;
    logic pos_ev, neg_ev, hold_hi_ev, hold_lo_ev, async_ev;

    // Each sample carries a tag saying whether it was taken inside the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            {s_clk, s_rst, s_d, s_q} <= 4'b0000;
            {p_clk, p_rst, p_d, p_q} <= 4'b0000;
            s_obs <= 1'b0;
            p_obs <= 1'b0;
        end else begin
            {s_clk, s_rst, s_d, s_q} <= {probe_clk, probe_rst, probe_d, probe_q};
            {p_clk, p_rst, p_d, p_q} <= {s_clk, s_rst, s_d, s_q};
            s_obs <= observe;
            p_obs <= s_obs;
        end
    end

    always_comb begin
        pe         = s_clk & ~p_clk;
        ne         = ~s_clk & p_clk;
        qchg       = s_q ^ p_q;
        armed      = p_d ^ p_q;
        count_en   = observe & s_obs & p_obs;
        pos_ev     = pe & armed & (s_q == p_d);
        neg_ev     = ne & armed & (s_q == p_d);
        hold_hi_ev = (pe | ne) & armed & ~s_q & p_rst;
        hold_lo_ev = (pe | ne) & armed & ~s_q & ~p_rst;
        // A drop coinciding with a clock edge is clock evidence, never async evidence.
        async_ev   = qchg & ~s_q & ~pe & ~ne;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos_hits   <= '0;
            neg_hits   <= '0;
            hold_hi    <= '0;
            hold_lo    <= '0;
            async_hits <= '0;
        end else if (count_en) begin
            if (pos_ev && (pos_hits != '1))       pos_hits   <= pos_hits + CNT_W'(1);
            if (neg_ev && (neg_hits != '1))       neg_hits   <= neg_hits + CNT_W'(1);
            if (hold_hi_ev && (hold_hi != '1))    hold_hi    <= hold_hi + CNT_W'(1);
            if (hold_lo_ev && (hold_lo != '1))    hold_lo    <= hold_lo + CNT_W'(1);
            if (async_ev && (async_hits != '1))   async_hits <= async_hits + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dff_cfg_identifier.sv
// Passively observes a flip-flop's pins for one window and decodes its 3-bit configuration.
module dff_cfg_identifier
    import dff_cfg_pkg::*;
#(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic probe_clk,
    input  logic probe_rst,
    input  logic probe_d,
    input  logic probe_q,
    output logic busy,
    output logic done,
    output logic cfg_valid,
    output cfg_t cfg
);

    localparam int unsigned WIN_W = $clog2(WINDOW);
    // OBSERVE spans WINDOW-1 cycles; DECIDE is the last busy cycle of the window.
    localparam logic [WIN_W-1:0] OBS_LAST = WIN_W'(WINDOW - 2);

    state_t           state, state_next;
    logic [WIN_W-1:0] win_cnt, win_next;
    logic             busy_next, done_next, valid_next;
    cfg_t             cfg_next, decision;
    logic             decision_valid, accept, observing;
    logic [CNT_W-1:0] pos_hits, neg_hits, hold_hi, hold_lo, async_hits;

    dff_cfg_evidence #(.CNT_W(CNT_W)) u_evidence (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .observe    (observing),
        .probe_clk  (probe_clk),
        .probe_rst  (probe_rst),
        .probe_d    (probe_d),
        .probe_q    (probe_q),
        .pos_hits   (pos_hits),
        .neg_hits   (neg_hits),
        .hold_hi    (hold_hi),
        .hold_lo    (hold_lo),
        .async_hits (async_hits)
    );

    always_comb begin
        decision           = '0;
        decision.neg_edge  = neg_hits > pos_hits;
        decision.rst_low   = hold_lo > hold_hi;
        decision.async_rst = async_hits != '0;
        decision_valid     = (pos_hits != neg_hits) && (hold_hi != hold_lo);
    end

    assign observing = (state == ST_OBSERVE);

    always_comb begin
        state_next = state;
        win_next   = win_cnt;
        busy_next  = busy;
        done_next  = 1'b0;
        valid_next = cfg_valid;
        cfg_next   = cfg;
        accept     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_OBSERVE;
                    win_next   = '0;
                    busy_next  = 1'b1;
                    valid_next = 1'b0;
                end
            end
            ST_OBSERVE: begin
                if (win_cnt == OBS_LAST) state_next = ST_DECIDE;
                else                     win_next   = win_cnt + WIN_W'(1);
            end
            ST_DECIDE: begin
                state_next = ST_DONE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                cfg_next   = decision;
                valid_next = decision_valid;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            win_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_valid <= 1'b0;
            cfg       <= '0;
        end else begin
            state     <= state_next;
            win_cnt   <= win_next;
            busy      <= busy_next;
            done      <= done_next;
            cfg_valid <= valid_next;
            cfg       <= cfg_next;
        end
    end

endmodule

// File: tb/tb_dff_cfg_identifier.sv
// Directed bench: drives probe pins from a small flip-flop stimulus generator, checks decoded config.
module tb_dff_cfg_identifier;
    import dff_cfg_pkg::*;

    localparam int unsigned WINDOW = 64;
    localparam int MODE_CONST = 0;
    localparam int MODE_A     = 1;
    localparam int MODE_B     = 2;
    localparam int MODE_F     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, probe_clk, probe_rst, probe_d, probe_q;
    logic busy, done, cfg_valid;
    logic [2:0] cfg;
    logic busy_s, done_s, cfg_valid_s;
    logic [2:0] cfg_s;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int mode = MODE_CONST;
    logic m_async, m_neg, m_low;
    logic prev_clk = 1'b0;
    logic prev_rst_act = 1'b0;
    logic prev_d = 1'b0;

    dff_cfg_identifier #(.WINDOW(WINDOW), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .probe_clk(probe_clk), .probe_rst(probe_rst), .probe_d(probe_d), .probe_q(probe_q),
        .busy(busy), .done(done), .cfg_valid(cfg_valid), .cfg(cfg)
    );

    dff_cfg_identifier #(.WINDOW(WINDOW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start),
        .probe_clk(probe_clk), .probe_rst(probe_rst), .probe_d(probe_d), .probe_q(probe_q),
        .busy(busy_s), .done(done_s), .cfg_valid(cfg_valid_s), .cfg(cfg_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observed flip-flop: pin patterns repeat every 8 cycles, clock period 4, d held at 1.
    task automatic drive_probes();
        int ph;
        logic pclk, prst, rst_act, edge_hit;
        ph   = n % 8;
        pclk = ((n % 4) >= 2);
        case (mode)
            MODE_A:  begin {m_async, m_neg, m_low} = 3'b000; prst = (ph >= 1 && ph <= 4); end
            MODE_B:  begin {m_async, m_neg, m_low} = 3'b111; prst = !(ph == 1 || ph == 2); end
            MODE_F:  begin {m_async, m_neg, m_low} = 3'b100; prst = (ph == 3 || ph == 4); end
            default: begin {m_async, m_neg, m_low} = 3'b000; prst = 1'b0; end
        endcase
        rst_act  = m_low ? !prst : prst;
        edge_hit = m_neg ? (prev_clk & !pclk) : (!prev_clk & pclk);
        if (m_async && rst_act)  probe_q = 1'b0;
        else if (edge_hit)       probe_q = (!m_async && prev_rst_act) ? 1'b0 : prev_d;
        probe_clk    = pclk;
        probe_rst    = prst;
        probe_d      = 1'b1;
        prev_clk     = pclk;
        prev_rst_act = rst_act;
        prev_d       = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        drive_probes();
    endtask

    task automatic run_window(input string tag, input int exp_cfg, input int exp_valid,
                              input int prev_cfg);
        int cycles;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_rise"}, int'(busy), 1);
        check({tag, "_valid_clr"}, int'(cfg_valid), 0);
        check({tag, "_cfg_hold"}, int'(cfg), prev_cfg);
        cycles = 1;
        while (!done && cycles < int'(WINDOW) + 20) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, int'(WINDOW) + 1);
        check({tag, "_busy_fall"}, int'(busy), 0);
        check({tag, "_cfg"}, int'(cfg), exp_cfg);
        check({tag, "_valid"}, int'(cfg_valid), exp_valid);
        tick();
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int cycles, dones, first_done;
        rst = 1'b1;
        start = 1'b0;
        probe_clk = 1'b0; probe_rst = 1'b0; probe_d = 1'b0; probe_q = 1'b0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(cfg_valid), 0);
        check("rst_cfg", int'(cfg), 0);
        check("rst_sat_state", int'({busy_s, done_s, cfg_valid_s, cfg_s}), 0);
        rst = 1'b0;

        // Posedge / sync / active-high: releases give pos hits, resets held while armed give hold_hi.
        mode = MODE_A;
        repeat (12) tick();
        run_window("A", int'(CFG_POS_SYNC_HIGH), 1, 0);

        // Negedge / async / active-low, reset asserted between clock edges.
        mode = MODE_B;
        repeat (10) tick();
        run_window("B", int'(CFG_NEG_ASYNC_LOW), 1, 0);
        check("B_async_seen", int'(dut.async_hits != 8'd0), 1);

        // Reset at window cycle 20 aborts with no done.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("D_busy", int'(busy), 0);
        check("D_valid", int'(cfg_valid), 0);
        check("D_cfg", int'(cfg), 0);
        check("D_cnt_clr", int'(dut.neg_hits), 0);
        dones = 0;
        repeat (WINDOW + 5) begin
            tick();
            if (done) dones++;
        end
        check("D_no_done", dones, 0);
        run_window("D_restart", int'(CFG_NEG_ASYNC_LOW), 1, 0);

        // Constant d and q: no armed edges, result inconclusive with all-zero partial decode.
        mode = MODE_CONST;
        repeat (10) tick();
        run_window("C", int'(CFG_POS_SYNC_HIGH), 0, int'(CFG_NEG_ASYNC_LOW));
        check("C_pos_zero", int'(dut.pos_hits), 0);
        check("C_neg_zero", int'(dut.neg_hits), 0);

        // Start re-asserted while busy is ignored: one done at WINDOW+1.
        mode = MODE_B;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        dones = 0;
        first_done = 0;
        for (int i = 0; i < int'(WINDOW) + 10; i++) begin
            start = (cycles == 10);
            tick();
            cycles++;
            if (done) begin
                dones++;
                if (first_done == 0) first_done = cycles;
            end
        end
        start = 1'b0;
        check("E_single_done", dones, 1);
        check("E_latency", first_done, int'(WINDOW) + 1);
        check("E_cfg", int'(cfg), int'(CFG_NEG_ASYNC_LOW));
        check("E_valid", int'(cfg_valid), 1);

        // Start from DONE; the narrow-counter instance must saturate rather than wrap.
        mode = MODE_F;
        repeat (10) tick();
        run_window("F", int'(CFG_POS_ASYNC_HIGH), 1, int'(CFG_NEG_ASYNC_LOW));
        check("F_sat_cfg", int'(cfg_s), int'(CFG_POS_ASYNC_HIGH));
        check("F_sat_valid", int'(cfg_valid_s), 1);
        check("F_sat_pos", int'(dut_sat.pos_hits), 3);
        check("F_sat_hold_hi", int'(dut_sat.hold_hi), 3);
        check("F_sat_async", int'(dut_sat.async_hits), 3);
        check("F_sat_hold_lo", int'(dut_sat.hold_lo), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
